serial_tx: RTL and testbench

- 8N1 UART transmitter driving the FPGA Tx line (avr_rx) toward the AVR USB bridge.
- Honours the AVR's Rx-buffer-full flag (avr_rx_busy) as flow control.
- Sits beside the top level and replaces the high-z tie-off on avr_rx.
- Host logic offers one byte at a time with a single-cycle strobe and watches busy.

---
 rtl/serial_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 33 +++
 rtl/serial_tx.sv | 132 +++++++++++++
 tb/tb_serial_tx.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial (UART) blocks: state encoding and baud default.
package serial_pkg;

  // Clock cycles per serial bit at 50 MHz / 500 kbaud.
  localparam int DEFAULT_CLK_PER_BIT = 100;

  // Transmitter state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous control inputs; clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;
  logic meta_d;
  logic sync_d;

  // Next values: the first flop captures the raw input, the second retimes it.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/serial_tx.sv
// 8N1 UART transmitter with flow control from the AVR Rx-buffer-full flag.
// A strobe is taken when idle and not busy, or on the final cycle of a stop bit
// (when the line is free of block), which lets frames run back to back with no
// idle gap. tx and busy are registered and change on the edge that takes the strobe.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT = DEFAULT_CLK_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       block,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic       busy,
  output logic       tx
);

  localparam int CTR_SIZE = $clog2(CLK_PER_BIT);
  localparam logic [CTR_SIZE-1:0] TIMER_LAST = CTR_SIZE'(CLK_PER_BIT - 1);

  state_t              state_q, state_d;
  logic [CTR_SIZE-1:0] timer_q, timer_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                block_s;
  logic                bit_done;

  sync_2ff u_block_sync (
    .clk (clk),
    .rst (rst),
    .d   (block),
    .q   (block_s)
  );

  // Next-state, bit timer, shift register and registered-output logic.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    bit_done  = (timer_q == TIMER_LAST);

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (new_data && !busy_q) begin
          shift_d   = data;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_done) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q + CTR_SIZE'(1);
        end
      end
      DATA: begin
        if (bit_done) begin
          timer_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + CTR_SIZE'(1);
        end
      end
      STOP: begin
        if (bit_done) begin
          timer_d = '0;
          // Last stop cycle: a strobe here starts the next frame with no gap.
          if (new_data && !block_s) begin
            shift_d   = data;
            bit_idx_d = '0;
            state_d   = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + CTR_SIZE'(1);
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Line level follows the state being entered so tx is glitch-free from a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE) | block_s;
  end

  // Control state and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  // Payload shift register; only meaningful once a byte has been taken.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: directed scenarios plus random traffic, checked every
// cycle against a frame-position model (where in a 10-bit frame each cycle falls).
module tb_serial_tx;

  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       block;
  logic [7:0] data;
  logic       new_data;
  logic       busy;
  logic       tx;

  serial_tx #(.CLK_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .block    (block),
    .data     (data),
    .new_data (new_data),
    .busy     (busy),
    .tx       (tx)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc    = 0;
  int         fstart = -1000;
  logic [7:0] fbyte  = 8'h00;
  bit         mb1 = 1'b0;
  bit         mb2 = 1'b0;
  bit         exp_busy = 1'b1;
  bit         exp_tx   = 1'b1;
  bit         cur_blk  = 1'b0;

  // Frame covering edge n exists when n lies in [fstart, fstart + FL).
  function automatic bit frame_active(input int n);
    return ((n - fstart) >= 0) && ((n - fstart) < FL);
  endfunction

  // Line level at edge n: start bit, LSB-first payload, stop bit.
  function automatic bit frame_level(input int n);
    logic [9:0] w;
    w = {1'b1, fbyte, 1'b0};
    return w[(n - fstart) / CPB];
  endfunction

  // One clock: drive inputs, advance the model, check tx and busy after the edge.
  task automatic tick(input bit nd, input logic [7:0] d, input bit r);
    bit acc;
    new_data = nd;
    data     = d;
    block    = cur_blk;
    rst      = r;
    @(posedge clk);
    cyc++;
    if (r) begin
      fstart   = -1000;
      exp_busy = 1'b1;
      mb1      = 1'b0;
      mb2      = 1'b0;
    end else begin
      acc = 1'b0;
      if (fstart + FL == cyc)
        acc = nd && !mb2;
      else if (!frame_active(cyc - 1))
        acc = nd && !exp_busy;
      if (acc) begin
        fstart = cyc;
        fbyte  = d;
      end
      exp_busy = frame_active(cyc) | mb2;
      mb2 = mb1;
      mb1 = cur_blk;
    end
    exp_tx = frame_active(cyc) ? frame_level(cyc) : 1'b1;
    #1;
    checks++;
    assert (tx === exp_tx) else begin
      errors++;
      $error("FAIL tx cyc=%0d got %b exp %b", cyc, tx, exp_tx);
    end
    checks++;
    assert (busy === exp_busy) else begin
      errors++;
      $error("FAIL busy cyc=%0d got %b exp %b", cyc, busy, exp_busy);
    end
    new_data = 1'b0;
    rst      = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [9:0] a5_bits;
    logic [9:0] got_bits;
    int         busy_cnt;
    bit         b2b_start_low;
    bit         nd_r;
    logic [7:0] d_r;

    rst = 1'b1; block = 1'b0; new_data = 1'b0; data = 8'h00;

    // Reset: tx idle high, busy high during reset.
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    idle(3);

    // Basic frame 0xA5: sequence 0,1,0,1,0,0,1,0,1,1 and 40 busy cycles.
    a5_bits  = 10'b1101001010;
    got_bits = '0;
    busy_cnt = 0;
    tick(1'b1, 8'hA5, 1'b0);
    for (int i = 0; i < FL + 5; i++) begin
      if (busy) busy_cnt++;
      if ((i < FL) && (i % CPB == CPB / 2)) got_bits[i / CPB] = tx;
      tick(1'b0, 8'h00, 1'b0);
    end
    checks++;
    assert (got_bits === a5_bits) else begin
      errors++;
      $error("FAIL a5_bits got %b exp %b", got_bits, a5_bits);
    end
    checks++;
    assert (busy_cnt === FL) else begin
      errors++;
      $error("FAIL a5_busy_len got %0d exp %0d", busy_cnt, FL);
    end

    // Strobe 0x3C in the middle of a 0x01 frame: dropped.
    tick(1'b1, 8'h01, 1'b0);
    idle(15);
    tick(1'b1, 8'h3C, 1'b0);
    idle(FL);

    // Back-to-back 0x55 then 0xFF: 80 contiguous busy cycles, start bit right after stop.
    busy_cnt      = 0;
    b2b_start_low = 1'b0;
    tick(1'b1, 8'h55, 1'b0);
    for (int i = 0; i < 2 * FL + 5; i++) begin
      if (busy) busy_cnt++;
      if (i == FL) b2b_start_low = !tx;
      if (i == FL - 1) tick(1'b1, 8'hFF, 1'b0);
      else             tick(1'b0, 8'h00, 1'b0);
    end
    checks++;
    assert (busy_cnt === 2 * FL) else begin
      errors++;
      $error("FAIL b2b_busy_len got %0d exp %0d", busy_cnt, 2 * FL);
    end
    checks++;
    assert (b2b_start_low === 1'b1) else begin
      errors++;
      $error("FAIL b2b_contiguous got %b exp %b", b2b_start_low, 1'b1);
    end

    // Flow control in IDLE: blocked strobe dropped, released strobe sent.
    cur_blk = 1'b1;
    idle(4);
    tick(1'b1, 8'h12, 1'b0);
    idle(20);
    cur_blk = 1'b0;
    idle(3);
    tick(1'b1, 8'h12, 1'b0);
    idle(FL + 3);

    // Block rising at bit 3 of 0xC3: frame intact, busy held until block drops.
    tick(1'b1, 8'hC3, 1'b0);
    idle(15);
    cur_blk = 1'b1;
    idle(FL);
    tick(1'b1, 8'h99, 1'b0);
    idle(3);
    cur_blk = 1'b0;
    idle(5);

    // Reset at bit 5 of 0x81, then a clean 0x7E frame.
    tick(1'b1, 8'h81, 1'b0);
    idle(6 * CPB);
    tick(1'b0, 8'h00, 1'b1);
    idle(3);
    tick(1'b1, 8'h7E, 1'b0);
    idle(FL + 3);

    // Random traffic with occasional block toggles and rare resets.
    for (int i = 0; i < 600; i++) begin
      nd_r = ($urandom_range(0, 5) == 0);
      d_r  = 8'($urandom);
      if ($urandom_range(0, 63) == 0) cur_blk = ~cur_blk;
      tick(nd_r, d_r, ($urandom_range(0, 399) == 0));
    end
    cur_blk = 1'b0;
    idle(FL + 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
